// File: rtl/gf180mcu_osu_sc_gp12t3v3__clkdiv_pkg.sv
// Shared types and default sizing for the multi-channel clock divider.
package gf180mcu_osu_sc_gp12t3v3__clkdiv_pkg;

  localparam int unsigned DefaultNch  = 4;
  localparam int unsigned DefaultDivW = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHi   = 2'd1,
    StLo   = 2'd2
  } chan_state_e;

endpackage

// File: rtl/gf180mcu_osu_sc_gp12t3v3__clkdiv_chan.sv
// One divider channel: HI/LO phase FSM, half-period counter, latched ratio and
// load handshake. Ratio loads are taken only in IDLE or on the LO terminal edge.
module gf180mcu_osu_sc_gp12t3v3__clkdiv_chan
  import gf180mcu_osu_sc_gp12t3v3__clkdiv_pkg::*;
#(
  parameter int unsigned DIV_W = DefaultDivW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             ld_req,
  input  logic             sync,
  output logic             ld_ack,
  output logic             y,
  output logic             stb,
  output logic             active
);

  chan_state_e      state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             y_q, y_d;
  logic             stb_q, stb_d;
  logic             ack_q, ack_d;
  logic             terminal;
  logic             boundary;
  logic             load;

  always_comb begin
    terminal = (cnt_q == div_q);
    boundary = (state_q == StIdle) || ((state_q == StLo) && terminal);
    load     = ld_req && !ack_q && boundary;

    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    stb_d   = 1'b0;
    ack_d   = load;
    div_d   = load ? div : div_q;

    // Phase alignment overrides the normal transition; the terminal compare
    // above still uses the old ratio so loads stay boundary-aligned.
    if (sync && (state_q != StIdle)) begin
      state_d = StHi;
      y_d     = 1'b1;
      stb_d   = 1'b1;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en) begin
            state_d = StHi;
            y_d     = 1'b1;
            stb_d   = 1'b1;
            cnt_d   = '0;
          end
        end
        StHi: begin
          if (terminal) begin
            state_d = StLo;
            y_d     = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
        StLo: begin
          if (terminal) begin
            cnt_d = '0;
            if (en) begin
              state_d = StHi;
              y_d     = 1'b1;
              stb_d   = 1'b1;
            end else begin
              state_d = StIdle;
              y_d     = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
        default: begin
          state_d = StIdle;
          y_d     = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      div_q   <= '0;
      y_q     <= 1'b0;
      stb_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      y_q     <= y_d;
      stb_q   <= stb_d;
      ack_q   <= ack_d;
    end
  end

  assign y      = y_q;
  assign stb    = stb_q;
  assign ld_ack = ack_q;
  assign active = (state_q != StIdle);

endmodule

// File: rtl/gf180mcu_osu_sc_gp12t3v3__clkdiv_n.sv
// NCH-channel glitch-free programmable clock divider. Define CLKDIV_SYNC_EN to
// add the SYNC input that phase-aligns all running channels.
module gf180mcu_osu_sc_gp12t3v3__clkdiv_n
  import gf180mcu_osu_sc_gp12t3v3__clkdiv_pkg::*;
#(
  parameter int unsigned NCH   = DefaultNch,
  parameter int unsigned DIV_W = DefaultDivW
) (
  input  logic                 CLK,
  input  logic                 RN,
  input  logic [NCH-1:0]       EN,
  input  logic [NCH*DIV_W-1:0] DIV,
  input  logic [NCH-1:0]       LD_REQ,
`ifdef CLKDIV_SYNC_EN
  input  logic                 SYNC,
`endif
  output logic [NCH-1:0]       LD_ACK,
  output logic [NCH-1:0]       Y,
  output logic [NCH-1:0]       STB,
  output logic [NCH-1:0]       ACTIVE
);

  logic sync;

`ifdef CLKDIV_SYNC_EN
  assign sync = SYNC;
`else
  assign sync = 1'b0;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    gf180mcu_osu_sc_gp12t3v3__clkdiv_chan #(
      .DIV_W(DIV_W)
    ) u_chan (
      .clk    (CLK),
      .rst_n  (RN),
      .en     (EN[i]),
      .div    (DIV[i*DIV_W +: DIV_W]),
      .ld_req (LD_REQ[i]),
      .sync   (sync),
      .ld_ack (LD_ACK[i]),
      .y      (Y[i]),
      .stb    (STB[i]),
      .active (ACTIVE[i])
    );
  end

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__clkdiv_n.sv
// Randomized bench for the clock divider against a period-position reference
// model: each running channel sits at position pos within a 2*(d+1) period.
module tb_gf180mcu_osu_sc_gp12t3v3__clkdiv_n;

  localparam int unsigned NCH   = 4;
  localparam int unsigned DIV_W = 8;
  localparam int unsigned NCYC  = 4000;

  logic                 CLK = 1'b0;
  logic                 RN  = 1'b0;
  logic [NCH-1:0]       EN  = '0;
  logic [NCH*DIV_W-1:0] DIV = '0;
  logic [NCH-1:0]       LD_REQ = '0;
  logic                 sync = 1'b0;
  logic [NCH-1:0]       LD_ACK, Y, STB, ACTIVE;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_active [NCH];
  int m_pos    [NCH];
  int m_d      [NCH];
  bit m_ack    [NCH];

  gf180mcu_osu_sc_gp12t3v3__clkdiv_n #(
    .NCH   (NCH),
    .DIV_W (DIV_W)
  ) dut (
    .CLK    (CLK),
    .RN     (RN),
    .EN     (EN),
    .DIV    (DIV),
    .LD_REQ (LD_REQ),
`ifdef CLKDIV_SYNC_EN
    .SYNC   (sync),
`endif
    .LD_ACK (LD_ACK),
    .Y      (Y),
    .STB    (STB),
    .ACTIVE (ACTIVE)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_active[i] = 1'b0;
      m_pos[i]    = 0;
      m_d[i]      = 0;
      m_ack[i]    = 1'b0;
    end
  endtask

  // Applies one rising edge with the inputs currently driven.
  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      int  per;
      bit  load;
      per  = 2 * (m_d[i] + 1);
      load = LD_REQ[i] && !m_ack[i] && (!m_active[i] || (m_pos[i] == per - 1));
      if (sync && m_active[i]) begin
        m_pos[i] = 0;
      end else if (!m_active[i]) begin
        if (EN[i]) begin
          m_active[i] = 1'b1;
          m_pos[i]    = 0;
        end
      end else if (m_pos[i] == per - 1) begin
        m_pos[i]    = 0;
        m_active[i] = EN[i];
      end else begin
        m_pos[i]++;
      end
      if (load) m_d[i] = int'(DIV[i*DIV_W +: DIV_W]);
      m_ack[i] = load;
    end
  endtask

  task automatic compare_all(input string phase);
    logic [NCH-1:0] ey, es, ea, ek;
    for (int i = 0; i < NCH; i++) begin
      ey[i] = m_active[i] && (m_pos[i] <= m_d[i]);
      es[i] = m_active[i] && (m_pos[i] == 0);
      ea[i] = m_active[i];
      ek[i] = m_ack[i];
    end
    check_eq({phase, "_y"},      32'(Y),      32'(ey));
    check_eq({phase, "_stb"},    32'(STB),    32'(es));
    check_eq({phase, "_active"}, 32'(ACTIVE), 32'(ea));
    check_eq({phase, "_ld_ack"}, 32'(LD_ACK), 32'(ek));
  endtask

  function automatic logic [DIV_W-1:0] pick_div();
    int r;
    r = int'($urandom % 16);
    if (r == 0) return '1;
    return DIV_W'(r % 5);
  endfunction

  initial begin
    model_reset();
    #2;
    compare_all("reset");
    @(negedge CLK);
    RN = 1'b1;
    // Channel 0 preloaded to CLK/2, channel 1 to DIV=3, both enabled.
    DIV[0 +: DIV_W]     = '0;
    DIV[DIV_W +: DIV_W] = DIV_W'(3);
    LD_REQ[1:0]         = 2'b11;
    EN[1:0]             = 2'b11;
    @(posedge CLK);
    model_step();

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge CLK);
      compare_all("run");
      if ((cyc % 900) == 450) begin
        RN = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
      end else if (!RN) begin
        RN = 1'b1;
      end
      for (int i = 0; i < NCH; i++) begin
        if (LD_REQ[i]) begin
          if (m_ack[i]) LD_REQ[i] = 1'b0;
        end else if (($urandom % 12) == 0) begin
          DIV[i*DIV_W +: DIV_W] = pick_div();
          LD_REQ[i] = 1'b1;
        end
        if (($urandom % 24) == 0) EN[i] = ~EN[i];
      end
`ifdef CLKDIV_SYNC_EN
      sync = (($urandom % 40) == 0);
`endif
      @(posedge CLK);
      if (RN) model_step();
    end

    @(negedge CLK);
    compare_all("final");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
